// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// A single OneBitAdder is stepped LSB first over WIDTH cycles. The carry is
// registered between bits, and the result is assembled in a shift register.
// The handshake is start/busy/done, with sum/cout held between operations.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port.
// When sub=1 the block computes a - b as a + ~b + 1.

module OneBitAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   opa_r, opa_s;
    logic [WIDTH-1:0]   opb_r, opb_s;
    logic [WIDTH-1:0]   res_r, res_s;
    logic [WIDTH-1:0]   sum_r, sum_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic               carry_r, carry_s;
    logic               cout_r, cout_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH:0]     res_shift_s;
    logic [WIDTH-1:0]   load_b_s;
    logic               load_c_s;

    // The one and only adder in the block; it sees the current LSBs and the carry.
    OneBitAdder u_fa (
        .a    (opa_r[0]),
        .b    (opb_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // New sum bit enters from the MSB side. Written this way, WIDTH=1 also works.
    assign res_shift_s = {fa_sum_s, res_r};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction loads the inverted B operand and a carry-in of one.
    assign load_b_s = sub ? ~b : b;
    assign load_c_s = sub;
`else
    assign load_b_s = b;
    assign load_c_s = 1'b0;
`endif

    // Compute the next state, the datapath next values and the handshake outputs.
    always_comb begin
        state_s = state_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        res_s   = res_r;
        sum_s   = sum_r;
        count_s = count_r;
        carry_s = carry_r;
        cout_s  = cout_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = RUN;
                    opa_s   = a;
                    opb_s   = load_b_s;
                    carry_s = load_c_s;
                    count_s = {CNT_W{1'b0}};
                    res_s   = {WIDTH{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                carry_s = fa_cout_s;
                res_s   = res_shift_s[WIDTH:1];
                opa_s   = opa_r >> 1'b1;
                opb_s   = opb_r >> 1'b1;
                count_s = count_r + CNT_ONE;
                if (count_r == LAST_BIT) begin
                    state_s = DONE;
                    sum_s   = res_shift_s[WIDTH:1];
                    cout_s  = fa_cout_s;
                    done_s  = 1'b1;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Register the state, the datapath and the outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            res_r   <= res_s;
            sum_r   <= sum_s;
            count_r <= count_s;
            carry_r <= carry_s;
            cout_r  <= cout_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that sequences a single one-bit full adder (`OneBitAdder`, ports a/b/cin/sum/cout) over WIDTH clock cycles to add two WIDTH-bit operands. It latches the operands on a start request and feeds them to the adder LSB first, registering the carry between bits. The assembled result is presented with a start/busy/done handshake. It sits between a requester and the shared one-bit adder datapath, trading area for latency.

## Interface
- WIDTH, 8: operand and result width in bits; legal range WIDTH >= 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- sub  input  1  subtract request; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result, held between operations.
- cout  output  1  final carry out, held between operations.

## Operation
- Instantiates exactly one `OneBitAdder`; no other adder logic is permitted.
- Internal state: operand shift registers opa/opb (WIDTH), carry flop, result shift register (WIDTH), bit counter ($clog2(WIDTH+1) bits).
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 -> RUN. Load opa=a, opb=b, carry=0, count=0.
- IDLE, start=0 -> stay in IDLE.
- RUN, every edge:
  - Adder inputs: a=opa[0], b=opb[0], cin=carry.
  - carry <= adder cout.
  - Shift the adder sum into the result register from the MSB side.
  - Shift opa and opb right by one.
  - count++.
- RUN, edge processing bit WIDTH-1 -> DONE.
  - Load sum with the completed result register.
  - cout <= adder cout.
  - done <= 1.
- DONE, start=1 -> RUN with a fresh operand load, identical to IDLE acceptance (back-to-back operation).
- DONE, start=0 -> IDLE.
- start in RUN is ignored. It is not queued.
- a/b/sub changes after acceptance have no effect on the operation in progress.
- The sum/cout outputs change only on the completion edge. They hold the previous result throughout RUN.
- Arithmetic: {cout,sum} == a + b modulo 2^(WIDTH+1). Overflow wraps into cout.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset (rst_n=0 at an edge):
  - State -> IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal registers cleared.
- Reset wins over all other inputs, including mid-RUN. An aborted operation produces no done pulse and does not update sum/cout.
- Start accepted at edge E0:
  - busy is high for exactly WIDTH cycles (after E0 until edge E0+WIDTH).
  - done is high for exactly one cycle, after edge E0+WIDTH.
  - sum/cout are valid from edge E0+WIDTH onward.
- Latency is WIDTH cycles from the accepting edge to done.
- Throughput: one operation per WIDTH+1 cycles with start held high. The DONE cycle itself accepts the next start.
- busy and done are never high simultaneously.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is latched at acceptance.
  - When sub=1: opb loads ~b, and carry initialises to 1, giving sum = a - b mod 2^WIDTH.
  - cout = 1 iff a >= b (unsigned no-borrow).
  - sub=0 behaves as plain addition.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port.
  - carry always initialises to 0; addition only.

## Test plan
- WIDTH=8. Reset asserted for 2 cycles, then released -> busy=0, done=0, sum=0x00, cout=0. Idle with start=0 for 10 cycles -> outputs unchanged.
- a=100, b=27, one-cycle start -> busy for 8 cycles, done pulse on the 8th edge after acceptance, sum=127, cout=0. Exhaustively repeat all 65536 a/b pairs against {cout,sum}==a+b.
- a=255, b=1 -> sum=0, cout=1. Change a/b and pulse start during RUN -> result unaffected, no second operation started.
- start held high across two operations (3+4, then 200+100) -> second RUN begins in the DONE cycle, results 7/cout 0 then 44/cout 1, done pulses 9 cycles apart.
- Start 10+20, assert rst_n=0 at the 4th RUN cycle -> no done pulse, sum=0, cout=0, state IDLE. Next start 1+2 -> sum=3.
- With SERIAL_ADDER_SUB_EN: 5-7 -> sum=254, cout=0. 7-5 -> sum=2, cout=1. 9-9 -> sum=0, cout=1.
